// File: rtl/snoop_bus_arbiter.sv
// snoop_bus_arbiter: owns the shared snooping bus. It grants one L1 cache at a
// time and walks each coherence transaction through broadcast, snoop, optional
// write-back, memory read and completion.
// Build option: define ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins
// arbitration; the default build arbitrates round-robin.
module snoop_bus_arbiter #(
    parameter int N       = 3,
    parameter int MEM_LAT = 2,
    parameter int AW      = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [2*N-1:0]  req_msg,
    input  logic [AW*N-1:0] req_addr,
    input  logic            wb_enable,
    input  logic [AW-1:0]   wb_addr,
    output logic [N-1:0]    gnt,
    output logic            bus_valid,
    output logic [1:0]      bus_msg,
    output logic [AW-1:0]   bus_addr,
    output logic            mem_we,
    output logic            mem_re,
    output logic [AW-1:0]   mem_addr,
    output logic [N-1:0]    done,
    output logic            busy
);

    localparam int         IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);
    localparam logic [1:0] MSG_INV  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BCAST,
        S_SNOOP,
        S_WB,
        S_MEM,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [1:0]      msg_q, msg_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            wb_q, wb_d;
    logic [AW-1:0]   wbaddr_q, wbaddr_d;
    logic [3:0]      cnt_q, cnt_d;

    logic [N-1:0]    elig;
    logic            any_elig;
    logic [IW-1:0]   win_idx;
    logic [1:0]      win_msg;
    logic [AW-1:0]   win_addr;

    // A cache competes only when it raises req with a real message.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N; i++) begin
            elig[i] = req[i] && (req_msg[2*i +: 2] != 2'd0);
        end
    end

`ifdef ARB_FIXED_PRIORITY_EN
    // Fixed priority: scan from the top so the lowest eligible index is kept last.
    always_comb begin
        any_elig = 1'b0;
        win_idx  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (elig[IW'(i)]) begin
                any_elig = 1'b1;
                win_idx  = IW'(i);
            end
        end
    end
`else
    logic [IW-1:0] ptr_q, ptr_d;

    // Round-robin: scan ptr+N down to ptr+1 so the nearest index after ptr wins.
    always_comb begin
        int j;
        any_elig = 1'b0;
        win_idx  = '0;
        j        = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(ptr_q) + k) % N;
            if (elig[IW'(j)]) begin
                any_elig = 1'b1;
                win_idx  = IW'(j);
            end
        end
    end

    // The pointer moves to the cache that just completed.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_DONE) begin
            ptr_d = idx_q;
        end
    end

    // Round-robin pointer; reset value N-1 makes cache 0 the first candidate.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= IW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Pick out the winning cache's message and address slices.
    always_comb begin
        win_msg  = '0;
        win_addr = '0;
        for (int i = 0; i < N; i++) begin
            if (win_idx == IW'(i)) begin
                win_msg  = req_msg[2*i +: 2];
                win_addr = req_addr[AW*i +: AW];
            end
        end
    end

    // Transaction sequencer: next state and the latched transaction fields.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        msg_d    = msg_q;
        addr_d   = addr_q;
        wb_d     = wb_q;
        wbaddr_d = wbaddr_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (any_elig) begin
                    idx_d   = win_idx;
                    msg_d   = win_msg;
                    addr_d  = win_addr;
                    wb_d    = 1'b0;
                    state_d = S_BCAST;
                end
            end
            S_BCAST: begin
                state_d = S_SNOOP;
            end
            S_SNOOP: begin
                wb_d     = wb_enable;
                wbaddr_d = wb_addr;
                if (wb_enable) begin
                    state_d = S_WB;
                end else if (msg_q == MSG_INV) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MEM;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_WB: begin
                if (msg_q == MSG_INV) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_MEM;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_MEM: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and transaction registers; reset abandons any transaction in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            msg_q    <= '0;
            addr_q   <= '0;
            wb_q     <= 1'b0;
            wbaddr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            msg_q    <= msg_d;
            addr_q   <= addr_d;
            wb_q     <= wb_d;
            wbaddr_q <= wbaddr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs decode from registered state only, so reset clears them at once.
    always_comb begin
        gnt       = '0;
        done      = '0;
        bus_valid = 1'b0;
        bus_msg   = '0;
        bus_addr  = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        busy      = (state_q != S_IDLE);
        for (int i = 0; i < N; i++) begin
            gnt[i]  = (state_q != S_IDLE) && (idx_q == IW'(i));
            done[i] = (state_q == S_DONE) && (idx_q == IW'(i));
        end
        case (state_q)
            S_BCAST: begin
                bus_valid = 1'b1;
                bus_msg   = msg_q;
                bus_addr  = addr_q;
            end
            S_WB: begin
                mem_we   = 1'b1;
                mem_addr = wbaddr_q;
            end
            S_MEM: begin
                // The counter still holds its load value only in the first MEM cycle.
                mem_re   = (cnt_q == CNT_LOAD);
                mem_addr = addr_q;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter (N=3, MEM_LAT=2, AW=3).
module tb_snoop_bus_arbiter;

    localparam int N       = 3;
    localparam int MEM_LAT = 2;
    localparam int AW      = 3;

    logic            clock;
    logic            reset;
    logic [N-1:0]    req;
    logic [2*N-1:0]  req_msg;
    logic [AW*N-1:0] req_addr;
    logic            wb_enable;
    logic [AW-1:0]   wb_addr;
    logic [N-1:0]    gnt;
    logic            bus_valid;
    logic [1:0]      bus_msg;
    logic [AW-1:0]   bus_addr;
    logic            mem_we;
    logic            mem_re;
    logic [AW-1:0]   mem_addr;
    logic [N-1:0]    done;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    snoop_bus_arbiter #(.N(N), .MEM_LAT(MEM_LAT), .AW(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_msg   (req_msg),
        .req_addr  (req_addr),
        .wb_enable (wb_enable),
        .wb_addr   (wb_addr),
        .gnt       (gnt),
        .bus_valid (bus_valid),
        .bus_msg   (bus_msg),
        .bus_addr  (bus_addr),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_addr  (mem_addr),
        .done      (done),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return on the falling edge where outputs are stable.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_req(input int i, input logic [1:0] m, input logic [AW-1:0] a);
        req[i]               = 1'b1;
        req_msg[2*i +: 2]    = m;
        req_addr[AW*i +: AW] = a;
    endtask

    task automatic clear_req();
        req      = '0;
        req_msg  = '0;
        req_addr = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    logic [N-1:0] exp_g;
    logic         seen_mem;

    initial begin
        reset     = 1'b1;
        req       = '0;
        req_msg   = '0;
        req_addr  = '0;
        wb_enable = 1'b0;
        wb_addr   = '0;

        // Reset state
        #12;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_bus_valid", 32'(bus_valid), 32'h0);
        chk("rst_mem", 32'({mem_we, mem_re, mem_addr}), 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Cache1 ReadMiss addr 5, no write-back
        set_req(1, 2'd2, 3'd5);
        step();
        chk("t1_bc_gnt", 32'(gnt), 32'h2);
        chk("t1_bc_valid", 32'(bus_valid), 32'h1);
        chk("t1_bc_msg", 32'(bus_msg), 32'h2);
        chk("t1_bc_addr", 32'(bus_addr), 32'h5);
        chk("t1_bc_busy", 32'(busy), 32'h1);
        chk("t1_bc_memaddr", 32'(mem_addr), 32'h0);
        step();
        chk("t1_sn_valid", 32'(bus_valid), 32'h0);
        chk("t1_sn_busmsg", 32'({bus_msg, bus_addr}), 32'h0);
        chk("t1_sn_mem", 32'({mem_we, mem_re}), 32'h0);
        step();
        chk("t1_m1_re", 32'(mem_re), 32'h1);
        chk("t1_m1_addr", 32'(mem_addr), 32'h5);
        chk("t1_m1_done", 32'(done), 32'h0);
        step();
        chk("t1_m2_re", 32'(mem_re), 32'h0);
        chk("t1_m2_addr", 32'(mem_addr), 32'h5);
        chk("t1_m2_done", 32'(done), 32'h0);
        step();
        chk("t1_done", 32'(done), 32'h2);
        chk("t1_done_gnt", 32'(gnt), 32'h2);
        clear_req();
        step();
        chk("t1_idle_busy", 32'(busy), 32'h0);
        chk("t1_idle_gnt", 32'(gnt), 32'h0);
        chk("t1_idle_done", 32'(done), 32'h0);

        // Cache0 WriteMiss addr 3, write-back of block 6 requested during snoop
        set_req(0, 2'd1, 3'd3);
        step();
        chk("t2_bc_gnt", 32'(gnt), 32'h1);
        chk("t2_bc_msg", 32'({bus_valid, bus_msg, bus_addr}), 32'({1'b1, 2'd1, 3'd3}));
        step();
        chk("t2_sn_we", 32'(mem_we), 32'h0);
        wb_enable = 1'b1;
        wb_addr   = 3'd6;
        step();
        wb_enable = 1'b0;
        wb_addr   = 3'd0;
        chk("t2_wb_we", 32'(mem_we), 32'h1);
        chk("t2_wb_re", 32'(mem_re), 32'h0);
        chk("t2_wb_addr", 32'(mem_addr), 32'h6);
        step();
        chk("t2_m1_we", 32'(mem_we), 32'h0);
        chk("t2_m1_re", 32'(mem_re), 32'h1);
        chk("t2_m1_addr", 32'(mem_addr), 32'h3);
        step();
        chk("t2_m2_done", 32'(done), 32'h0);
        step();
        chk("t2_done", 32'(done), 32'h1);
        clear_req();
        step();
        chk("t2_idle_busy", 32'(busy), 32'h0);

        // Cache2 Invalidate addr 1: no memory traffic, done three cycles on
        set_req(2, 2'd3, 3'd1);
        seen_mem = 1'b0;
        step();
        chk("t3_bc_gnt", 32'(gnt), 32'h4);
        chk("t3_bc_msg", 32'({bus_valid, bus_msg, bus_addr}), 32'({1'b1, 2'd3, 3'd1}));
        seen_mem = seen_mem | mem_re | mem_we;
        step();
        chk("t3_sn_done", 32'(done), 32'h0);
        seen_mem = seen_mem | mem_re | mem_we;
        step();
        chk("t3_done", 32'(done), 32'h4);
        seen_mem = seen_mem | mem_re | mem_we;
        chk("t3_no_mem", 32'(seen_mem), 32'h0);
        clear_req();
        step();
        chk("t3_idle_busy", 32'(busy), 32'h0);

        // All caches request ReadMiss continuously from reset
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 2'd2, 3'(i));
        for (int k = 0; k < 4; k++) begin
            step();
`ifdef ARB_FIXED_PRIORITY_EN
            exp_g = 3'b001;
`else
            exp_g = 3'b001 << (k % N);
`endif
            chk($sformatf("t4_order%0d", k), 32'(gnt), 32'(exp_g));
            repeat (5) step();
        end
        clear_req();
        do_reset();

        // A request with msg Nada is ignored
        set_req(1, 2'd0, 3'd4);
        step();
        chk("t5_gnt_a", 32'(gnt), 32'h0);
        chk("t5_busy_a", 32'(busy), 32'h0);
        step();
        step();
        chk("t5_gnt_b", 32'(gnt), 32'h0);
        chk("t5_busy_b", 32'(busy), 32'h0);
        clear_req();

        // Reset asserted during MEM abandons the transaction
        set_req(1, 2'd2, 3'd7);
        step();
        chk("t6_bc_gnt", 32'(gnt), 32'h2);
        for (int i = 0; i < N; i++) set_req(i, 2'd2, 3'(i + 1));
        step();
        step();
        chk("t6_mem_re", 32'(mem_re), 32'h1);
        chk("t6_mem_addr", 32'(mem_addr), 32'h7);
        reset = 1'b1;
        #1;
        chk("t6_async_gnt", 32'(gnt), 32'h0);
        chk("t6_async_mem", 32'({mem_we, mem_re, mem_addr}), 32'h0);
        chk("t6_async_busy", 32'(busy), 32'h0);
        chk("t6_async_done", 32'(done), 32'h0);
        @(negedge clock);
        step();
        chk("t6_hold_done", 32'(done), 32'h0);
        chk("t6_hold_gnt", 32'(gnt), 32'h0);
        reset = 1'b0;
        step();
        chk("t6_rearb_gnt", 32'(gnt), 32'h1);
        chk("t6_rearb_addr", 32'(bus_addr), 32'h1);
        clear_req();
        repeat (6) step();
        chk("t6_end_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Arbitrates the shared snooping bus between N L1 cache controllers and sequences each coherence transaction: broadcast, snoop, optional write-back, memory read, completion.
- Sits between the CacheL1 instances and the shared memory array in the snooping top level.
- Replaces the free-running step counter as the owner of transaction sequencing.

Parameters:
- N, 3, number of requesting caches (2..8).
- MEM_LAT, 2, cycles the memory read phase lasts (1..15).
- AW, 3, bus/memory address width.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  N  per-cache bus request; held until that cache's done.
- req_msg  in  2N  per-cache message; slice i = [2i+1:2i]; 0=Nada, 1=WriteMiss, 2=ReadMiss, 3=Invalidate.
- req_addr  in  AW*N  per-cache block address; slice i = [AW*i+AW-1:AW*i].
- wb_enable  in  1  a snooping cache holds the block Modified and must write back.
- wb_addr  in  AW  address of the write-back block.
- gnt  out  N  one-hot bus grant.
- bus_valid  out  1  bus_msg/bus_addr valid (BCAST only).
- bus_msg  out  2  broadcast message.
- bus_addr  out  AW  broadcast address.
- mem_we  out  1  memory write strobe (write-back).
- mem_re  out  1  memory read strobe.
- mem_addr  out  AW  memory address.
- done  out  N  one-cycle completion pulse to the granted cache.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, any state, mid-transaction included): state=IDLE, rr pointer=N-1 (cache 0 first), all outputs 0, latched msg/addr/wb flag 0, latency counter 0. Transaction in flight is abandoned with no done pulse.
- Eligibility: cache i is eligible when req[i]=1 and msg_i≠0. A request with msg=0 is ignored.
- Arbitration (round-robin):
  - In IDLE with any eligible cache, pick the first eligible index scanning ptr+1, ptr+2, … mod N.
  - Latch its index, msg and addr, then go to BCAST.
  - ptr updates to the winner on DONE exit.
- Grant: gnt one-hot, asserted from BCAST through DONE inclusive; 0 in IDLE. Requests arriving during a transaction wait. req changes after the grant are ignored; the latched transaction completes.
- States:
  - IDLE: described above.
  - BCAST: 1 cycle. bus_valid=1; bus_msg/bus_addr = latched values.
  - SNOOP: 1 cycle. Sample wb_enable and wb_addr into the wb flag/address.
    - wb flag set → WB.
    - Else, msg=Invalidate → DONE.
    - Else → MEM.
  - WB: 1 cycle. mem_we=1, mem_addr=latched wb_addr.
    - Invalidate → DONE.
    - Else → MEM.
  - MEM: exactly MEM_LAT cycles. mem_re=1 in the first cycle only; mem_addr=latched addr throughout. A 4-bit counter loads MEM_LAT-1 on entry and decrements; at 0 → DONE.
  - DONE: 1 cycle. done[idx]=1, then IDLE.
- Latency from the IDLE cycle that samples req:
  - Invalidate, no wb: done after 3 cycles.
  - Miss, no wb: done after 3+MEM_LAT cycles.
  - Write-back adds 1 cycle.
- Back-to-back: IDLE is always visited for 1 cycle between transactions, so the minimum spacing is 4 cycles (Invalidate).
- mem_addr outside WB/MEM is 0. bus_msg/bus_addr are 0 when bus_valid=0.

Optional Feature:
- Macro ARB_FIXED_PRIORITY_EN.
- Defined: fixed priority, lowest eligible index wins; rr pointer is not implemented.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then req=3'b010, cache1 msg=2 (ReadMiss) addr=5, wb_enable=0, MEM_LAT=2 → gnt=010 for 5 cycles; bus_valid with msg=2/addr=5 one cycle later; mem_re with mem_addr=5; done=010 on cycle 5; busy drops after.
- Cache0 WriteMiss addr=3, wb_enable=1 with wb_addr=6 in SNOOP → mem_we=1 mem_addr=6 for 1 cycle, then mem_re mem_addr=3, done=001 one cycle later than the no-wb case.
- Cache2 Invalidate addr=1, no wb → mem_re and mem_we never asserted; done=100 three cycles after request.
- All three caches request continuously (ReadMiss) from reset → grant order 0,1,2,0,…; with ARB_FIXED_PRIORITY_EN the order is 0,0,0 while req[0] is held.
- req[1]=1 with msg=0 → no grant; busy stays 0.
- Assert reset during MEM → all outputs 0 immediately (async); no done. After release, the pending request is re-arbitrated from IDLE with cache 0 having priority.
